// File: rtl/pwm_duty_meter_pkg.sv
// Shared types and constants for the PWM duty meter.
package pwm_duty_meter_pkg;

    typedef enum logic [1:0] {
        ACQUIRE = 2'd0,
        HIGH    = 2'd1,
        LOW     = 2'd2
    } meter_state_t;

    localparam int PCT_SCALE = 100;
    localparam int DUTY_W    = 7;

    // Numerator width for high*PCT_SCALE given a counter width.
    function automatic int num_width(input int cnt_w);
        return cnt_w + DUTY_W;
    endfunction

endpackage

// File: rtl/pwm_duty_meter_if.sv
// Result bus of the PWM duty meter: captured counts, duty and status strobes.
interface pwm_duty_meter_if
    import pwm_duty_meter_pkg::*;
#(
    parameter int CNT_W = 16
);
    logic [CNT_W-1:0]  high_cnt;
    logic [CNT_W-1:0]  period_cnt;
    logic [DUTY_W-1:0] duty_pct;
    logic              valid;
    logic              stuck;
    logic              overrun;

    modport master (
        output high_cnt, period_cnt, duty_pct, valid, stuck, overrun
    );

    modport slave (
        input high_cnt, period_cnt, duty_pct, valid, stuck, overrun
    );
endinterface

// File: rtl/pwm_duty_meter_seq_div.sv
// Unsigned restoring divider, one quotient bit per cycle, NUM_W cycles per divide.
// done pulses on the cycle after the last step; abort drops any divide in flight.
module pwm_seq_div #(
    parameter int NUM_W = 23,
    parameter int DEN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [NUM_W-1:0] num,
    input  logic [DEN_W-1:0] den,
    output logic             busy,
    output logic             done,
    output logic [NUM_W-1:0] quo
);
    localparam int SW = $clog2(NUM_W + 1);

    logic [DEN_W-1:0] rem_q;
    logic [DEN_W-1:0] den_q;
    logic [NUM_W-1:0] quo_q;
    logic [SW-1:0]    step_q;
    logic             busy_q;
    logic             done_q;

    logic [DEN_W:0]   rem_sh;
    logic             ge;
    logic [DEN_W-1:0] rem_nx;

    // One restoring step: shift in the next numerator bit and try to subtract.
    always_comb begin
        rem_sh = {rem_q, quo_q[NUM_W-1]};
        ge     = (rem_sh >= {1'b0, den_q});
        rem_nx = ge ? DEN_W'(rem_sh - {1'b0, den_q}) : rem_sh[DEN_W-1:0];
    end

    // Divide sequencing; the step counter runs down from NUM_W to the last step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            den_q  <= '0;
            quo_q  <= '0;
            step_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else if (abort) begin
            step_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start && !busy_q) begin
                rem_q  <= '0;
                den_q  <= den;
                quo_q  <= num;
                step_q <= SW'(NUM_W);
                busy_q <= 1'b1;
            end else if (busy_q) begin
                rem_q  <= rem_nx;
                quo_q  <= {quo_q[NUM_W-2:0], ge};
                step_q <= step_q - 1'b1;
                if (step_q == SW'(1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign quo  = quo_q;

endmodule

// File: rtl/pwm_duty_meter.sv
// PWM duty meter: measures high time and period of a sampled PWM line and
// reports floor(high*100/period) with a one-cycle valid strobe.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ACQUIRE | no measurement running; waiting for the first rise event
// HIGH    | line high; high and period counters running
// LOW     | line low; period counter running, next rise completes a period
module pwm_duty_meter
    import pwm_duty_meter_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pwm_in,
    pwm_duty_meter_if.master  res
);
    localparam int NUM_W = num_width(CNT_W);
    localparam logic [CNT_W-1:0] SAT     = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] TO_LOAD = CNT_W'(TIMEOUT_CYC - 1);

    logic [1:0]       sync_q;
    logic             edge_q;
    logic             pin_lvl;
    logic             rise;
    logic             fall;

    meter_state_t     state_q, state_d;
    logic             restart, hi_inc, per_inc, div_start, ovr_d;

    logic [CNT_W-1:0] high_c, per_c;
    logic [CNT_W-1:0] stg_high, stg_per;
    logic [CNT_W-1:0] to_cnt_q;
    logic             timeout;

    logic             div_busy, div_done;
    logic [NUM_W-1:0] div_num, div_quo;
    logic [DUTY_W-1:0] duty_clamped;

    // Two-flop synchronizer plus the edge-detect register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], pwm_in};
            edge_q <= sync_q[1];
        end
    end

    assign pin_lvl = sync_q[1];
    assign rise    = pin_lvl & ~edge_q;
    assign fall    = ~pin_lvl & edge_q;

    // Stuck-line timer: reloads on every rise event and on each expiry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= TO_LOAD;
        end else if (rise || timeout) begin
            to_cnt_q <= TO_LOAD;
        end else begin
            to_cnt_q <= to_cnt_q - 1'b1;
        end
    end

    // A rise in the same cycle suppresses expiry.
    assign timeout = (to_cnt_q == '0) && !rise;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACQUIRE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and counter/divider control.
    always_comb begin
        state_d   = state_q;
        restart   = 1'b0;
        hi_inc    = 1'b0;
        per_inc   = 1'b0;
        div_start = 1'b0;
        ovr_d     = 1'b0;
        if (timeout) begin
            state_d = ACQUIRE;
        end else begin
            unique case (state_q)
                ACQUIRE: begin
                    if (rise) begin
                        restart = 1'b1;
                        state_d = HIGH;
                    end
                end
                HIGH: begin
                    per_inc = 1'b1;
                    if (fall) begin
                        state_d = LOW;
                    end else begin
                        hi_inc = 1'b1;
                    end
                end
                LOW: begin
                    if (rise) begin
                        restart = 1'b1;
                        state_d = HIGH;
                        if (div_busy) begin
                            ovr_d = 1'b1;
                        end else begin
                            div_start = 1'b1;
                        end
                    end else begin
                        per_inc = 1'b1;
                    end
                end
                default: state_d = ACQUIRE;
            endcase
        end
    end

    // High and period counters: restart at 1, saturate at the timeout value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            high_c <= '0;
            per_c  <= '0;
        end else if (restart) begin
            high_c <= CNT_W'(1);
            per_c  <= CNT_W'(1);
        end else begin
            if (hi_inc && high_c != SAT) begin
                high_c <= high_c + 1'b1;
            end
            if (per_inc && per_c != SAT) begin
                per_c <= per_c + 1'b1;
            end
        end
    end

    // Staging copy of the period being divided, published when the quotient is ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_high <= '0;
            stg_per  <= '0;
        end else if (div_start) begin
            stg_high <= high_c;
            stg_per  <= per_c;
        end
    end

    assign div_num = NUM_W'(high_c) * NUM_W'(PCT_SCALE);

    pwm_seq_div #(
        .NUM_W (NUM_W),
        .DEN_W (CNT_W)
    ) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .start (div_start),
        .abort (timeout),
        .num   (div_num),
        .den   (per_c),
        .busy  (div_busy),
        .done  (div_done),
        .quo   (div_quo)
    );

    // Jitter on the sampled edges can push the ratio past full scale.
    assign duty_clamped = (div_quo > NUM_W'(PCT_SCALE)) ? DUTY_W'(PCT_SCALE)
                                                        : div_quo[DUTY_W-1:0];

    // Result registers: timeout report has priority over a finishing divide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res.high_cnt   <= '0;
            res.period_cnt <= '0;
            res.duty_pct   <= '0;
            res.valid      <= 1'b0;
            res.stuck      <= 1'b0;
            res.overrun    <= 1'b0;
        end else begin
            res.valid   <= 1'b0;
            res.overrun <= ovr_d;
            if (timeout) begin
                res.high_cnt   <= '0;
                res.period_cnt <= '0;
                res.duty_pct   <= pin_lvl ? DUTY_W'(PCT_SCALE) : '0;
                res.stuck      <= 1'b1;
                res.valid      <= 1'b1;
            end else if (div_done) begin
                res.high_cnt   <= stg_high;
                res.period_cnt <= stg_per;
                res.duty_pct   <= duty_clamped;
                res.stuck      <= 1'b0;
                res.valid      <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Bench for pwm_duty_meter: drives PWM waveforms, queues the expected result of
// every completed period and compares each valid strobe against the queue.
module tb_pwm_duty_meter;
    import pwm_duty_meter_pkg::*;

    localparam int CNT_W = 16;
    localparam int T     = 600;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pwm_in = 1'b0;

    pwm_duty_meter_if #(.CNT_W(CNT_W)) res ();

    pwm_duty_meter #(
        .CNT_W       (CNT_W),
        .TIMEOUT_CYC (T)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .pwm_in (pwm_in),
        .res    (res)
    );

    always #5 clk = ~clk;

    typedef struct {
        int hi;
        int per;
        int stuck;
        int duty;
    } rec_t;

    typedef struct {
        int hi;
        int per;
        int reps;
        int exp_duty;
    } vec_t;

    rec_t sb_q[$];
    vec_t vecs[6];

    int errors = 0;
    int checks = 0;
    bit free_mode = 1'b0;
    int free_valids = 0;
    int ovr_cnt = 0;

    bit prev_active = 1'b0;
    int cur_hi = 0;
    int cur_per = 0;
    int cur_exp = 0;

    // Drive a level for n cycles; a rising drive completes the period in progress.
    task automatic drive_level(input logic lvl, input int n);
        if (lvl && !pwm_in) begin
            if (prev_active && !free_mode)
                sb_q.push_back('{cur_hi, cur_per, 0, cur_exp});
            cur_hi = 0;
            cur_per = 0;
            prev_active = 1'b1;
        end
        pwm_in = lvl;
        repeat (n) begin
            @(posedge clk);
            #1;
            cur_per++;
            if (lvl) cur_hi++;
        end
    endtask

    task automatic drive_period(input int hi, input int per, input int exp_d);
        drive_level(1'b1, hi);
        cur_exp = exp_d;
        drive_level(1'b0, per - hi);
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (res.high_cnt !== '0 || res.period_cnt !== '0 || res.duty_pct !== '0 ||
            res.valid !== 1'b0 || res.stuck !== 1'b0 || res.overrun !== 1'b0) begin
            errors++;
            $display("FAIL %s: got hi=%0d per=%0d duty=%0d v=%0b st=%0b ov=%0b, need all 0",
                     name, res.high_cnt, res.period_cnt, res.duty_pct,
                     res.valid, res.stuck, res.overrun);
        end
    endtask

    initial begin
        int n;
        vecs[0] = '{50, 101, 4, 49};
        vecs[1] = '{150, 200, 3, 75};
        vecs[2] = '{20, 200, 3, 10};
        vecs[3] = '{1, 30, 3, 3};
        vecs[4] = '{29, 30, 3, 96};
        vecs[5] = '{10, 40, 3, 25};

        fork
            // Result monitor / scoreboard.
            forever begin
                @(negedge clk);
                if (rst_n) begin
                    if (res.valid) begin
                        if (sb_q.size() > 0) begin
                            rec_t e;
                            e = sb_q.pop_front();
                            checks++;
                            if (res.high_cnt !== e.hi[CNT_W-1:0] ||
                                res.period_cnt !== e.per[CNT_W-1:0] ||
                                res.duty_pct !== e.duty[DUTY_W-1:0] ||
                                res.stuck !== e.stuck[0]) begin
                                errors++;
                                $display("FAIL result: got hi=%0d per=%0d duty=%0d stuck=%0b, need hi=%0d per=%0d duty=%0d stuck=%0d",
                                         res.high_cnt, res.period_cnt, res.duty_pct, res.stuck,
                                         e.hi, e.per, e.duty, e.stuck);
                            end
                        end else if (free_mode) begin
                            free_valids++;
                            checks++;
                            if (res.high_cnt !== 16'd2 || res.period_cnt !== 16'd4 ||
                                res.duty_pct !== 7'd50 || res.stuck !== 1'b0) begin
                                errors++;
                                $display("FAIL short_period: got hi=%0d per=%0d duty=%0d stuck=%0b, need 2/4/50/0",
                                         res.high_cnt, res.period_cnt, res.duty_pct, res.stuck);
                            end
                        end else begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_valid: got hi=%0d per=%0d duty=%0d, need no valid",
                                     res.high_cnt, res.period_cnt, res.duty_pct);
                        end
                    end
                    if (res.overrun) begin
                        ovr_cnt++;
                        if (!free_mode) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_overrun: got 1, need 0");
                        end
                    end
                end
            end
            // Global watchdog.
            begin
                repeat (30000) @(posedge clk);
                $display("FAIL watchdog: simulation still running, need completion");
                errors++;
                $display("Result: errors=%0d of %0d checks", errors, checks + 1);
                $fatal(1);
            end
        join_none

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset_outputs");
        rst_n = 1'b1;

        // Line low from reset: stuck-low report after the timeout.
        sb_q.push_back('{0, 0, 1, 0});
        n = 0;
        while (n < T + 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (res.valid) break;
        end
        checks++;
        if (n < T || n > T + 3) begin
            errors++;
            $display("FAIL stuck_low_latency: got %0d cycles, need %0d..%0d", n, T, T + 3);
        end
        @(posedge clk);
        #1;

        // Table-driven periodic waveforms, switching mid-stream between entries.
        foreach (vecs[i]) begin
            for (int r = 0; r < vecs[i].reps; r++)
                drive_period(vecs[i].hi, vecs[i].per, vecs[i].exp_duty);
        end

        // Line stuck high for three timeout intervals, then normal PWM again.
        drive_level(1'b1, 1);
        for (int k = 0; k < 3; k++)
            sb_q.push_back('{0, 0, 1, 100});
        drive_level(1'b1, 3 * T + 19);
        prev_active = 1'b0;
        drive_level(1'b0, 30);
        for (int r = 0; r < 3; r++)
            drive_period(50, 101, 49);

        // Period shorter than the divider latency.
        drive_level(1'b1, 2);
        free_mode = 1'b1;
        cur_exp = 50;
        drive_level(1'b0, 2);
        for (int r = 0; r < 59; r++)
            drive_period(2, 4, 50);
        drive_level(1'b0, 40);
        free_mode = 1'b0;
        cur_exp = 4;
        checks++;
        if (ovr_cnt < 20) begin
            errors++;
            $display("FAIL overrun_count: got %0d, need >= 20", ovr_cnt);
        end
        checks++;
        if (free_valids < 5) begin
            errors++;
            $display("FAIL short_valid_count: got %0d, need >= 5", free_valids);
        end

        // Reset in the middle of a divide.
        drive_period(50, 101, 49);
        drive_period(50, 101, 49);
        drive_level(1'b1, 10);
        rst_n = 1'b0;
        #1;
        check_zero("reset_mid_divide");
        sb_q.delete();
        prev_active = 1'b0;
        pwm_in = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_zero("reset_hold");
        rst_n = 1'b1;
        for (int r = 0; r < 3; r++)
            drive_period(50, 101, 49);
        repeat (40) @(posedge clk);
        #1;

        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL missing_valids: got %0d results outstanding, need 0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
